// File: rtl/mul32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier with a start/done handshake.
// It adds one partial product per cycle through a shared 32-bit carry-lookahead adder.

module cla32_ov (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] sum,
    output logic        co,
    output logic        co_prev
);
    logic [31:0] g;
    logic [31:0] pr;

    assign g  = a & b;
    assign pr = a ^ b;

    // Carries are looked ahead inside each 4-bit group, and group carries chain between groups.
    always_comb begin
        logic       carry;
        logic [3:0] g4;
        logic [3:0] p4;
        logic [3:0] c4;
        sum     = '0;
        co_prev = 1'b0;
        carry   = ci;
        g4      = '0;
        p4      = '0;
        c4      = '0;
        for (int j = 0; j < 8; j++) begin
            g4    = g[4*j +: 4];
            p4    = pr[4*j +: 4];
            c4[0] = carry;
            c4[1] = g4[0] | (p4[0] & carry);
            c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & carry);
            c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                  | (p4[2] & p4[1] & p4[0] & carry);
            sum[4*j +: 4] = p4 ^ c4;
            co_prev = c4[3];
            carry = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                  | (p4[3] & p4[2] & p4[1] & g4[0]) | ((&p4) & carry);
        end
        co = carry;
    end
endmodule

// state | meaning
// IDLE  | waiting for start
// BUSY  | 32 shift-add iterations in progress
// DONE  | one-cycle completion, p/ov freshly loaded; start here chains the next operation
module mul32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] p,
    output logic        ov
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [31:0] m;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic [31:0] sum;
    logic        co;
    logic        adder_co_prev_unused;
    logic [63:0] acc_next;

    cla32_ov adder (
        .a       (acc[63:32]),
        .b       (m),
        .ci      (1'b0),
        .sum     (sum),
        .co      (co),
        .co_prev (adder_co_prev_unused)
    );

    // The adder carry becomes bit 63 after the shift; without it large products are wrong.
    always_comb begin
        acc_next = {1'b0, acc[63:32], acc[31:1]};
        if (acc[0])
            acc_next = {co, sum, acc[31:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m     <= a;
                        acc   <= {32'b0, b};
                        cnt   <= '0;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        p     <= acc_next;
                        ov    <= |acc_next[63:32];
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);
endmodule

// File: tb/tb_mul32_seq.sv
// Scoreboard bench for mul32_seq: expected products come from plain 64-bit multiplication
// and are checked by a monitor whenever done is presented.

module tb_mul32_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] p;
    logic        ov;

    typedef struct {
        logic [63:0] p;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   done_seen = 0;

    mul32_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .ov    (ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total_cnt++;
        if (act === want)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.p  = 64'(x) * 64'(y);
        e.ov = (e.p >= 64'h1_0000_0000);
        return e;
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && done) begin
            done_seen++;
            chk("done_has_request", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("product", p, mon_e.p);
                chk("ov", 64'(ov), 64'(mon_e.ov));
            end
        end
    end

    // Issue one operation and time it; returns 1ns after the edge that raises done.
    task automatic go(input logic [31:0] x, input logic [31:0] y);
        int   n;
        logic bad;
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        bad = 1'b0;
        while (!done && n < 40) begin
            if (!busy) bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("busy_during_op", 64'(bad), 64'd0);
        chk("latency", 64'(n), 64'd32);
        chk("busy_at_done", 64'(busy), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] x0;
        logic [31:0] y0;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        bad;
        int          ds;

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #2;
        chk("reset_p", p, 64'd0);
        chk("reset_flags", 64'({busy, done, ov}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy || done || ov || (p != 64'd0)) bad = 1'b1;
            @(posedge clk); #1;
        end
        chk("idle_quiet", 64'(bad), 64'd0);

        go(32'd3, 32'd5);
        idle(5);
        chk("p_held", p, 64'd15);
        chk("done_cleared", 64'(done), 64'd0);

        go(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(2);
        go(32'h0001_0000, 32'h0001_0000);
        idle(1);
        go(32'h0, 32'hDEAD_BEEF);
        idle(3);

        // Starts at edges 10 and 32 land while BUSY and must be ignored.
        ds = done_seen;
        x0 = $urandom;
        y0 = $urandom;
        a = x0;
        b = y0;
        start = 1'b1;
        exp_q.push_back(model(x0, y0));
        @(posedge clk); #1;
        for (int e = 1; e <= 32; e++) begin
            start = (e == 10 || e == 32);
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("pulse_done_timing", 64'(done), 64'd1);
        idle(40);
        chk("pulse_single_done", 64'(done_seen - ds), 64'd1);

        go(32'd9, 32'd11);
        go(32'd7, 32'd6);
        idle(2);
        chk("chained_p", p, 64'd42);

        for (int i = 0; i < 8; i++) begin
            rx = $urandom;
            ry = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 65535));
            if (i % 3 == 0) rx = 32'($urandom_range(0, 65535));
            go(rx, ry);
            idle($urandom_range(0, 3));
        end

        go(32'd123, 32'd456);
        idle(2);
        a = $urandom;
        b = $urandom;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_p", p, 64'd0);
        chk("abort_flags", 64'({busy, done, ov}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ds = done_seen;
        idle(40);
        chk("no_done_after_abort", 64'(done_seen - ds), 64'd0);

        go(32'd100, 32'd200);
        idle(3);
        chk("after_abort_p", p, 64'd20000);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
